// File: rtl/id_pkg.sv
// Shared CPU definitions: ALU operation codes and RV32 opcode/funct constants
// used by the decode stage and the execute stage.
package id_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } aluop_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 to ALU operation, shared by register and immediate forms
    function automatic aluop_e funct3_to_aluop(input logic [2:0] funct3);
        aluop_e op;
        case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_dec.sv
// Combinational instruction decoder: register addresses, ALU operation,
// immediate, operand selects and illegal-instruction detection.
module id_dec #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 3
) (
    input  logic [XLEN-1:0]    instr,
    output logic [4:0]         rs1_addr,
    output logic [4:0]         rs2_addr,
    output logic [4:0]         rd,
    output logic [ALUOP_W-1:0] aluop,
    output logic [XLEN-1:0]    imm,
    output logic               pc_en,
    output logic               imm_en,
    output logic               illegal
);
    import id_pkg::*;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    aluop_e          aluop_s;
    logic [XLEN-1:0] imm_s;
    logic            pc_en_s;
    logic            imm_en_s;
    logic            illegal_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign rs2_addr = instr[24:20];

    // Raw decode of the supported RV32I integer subset
    always_comb begin
        aluop_s   = ALU_ADD;
        imm_s     = '0;
        pc_en_s   = 1'b0;
        imm_en_s  = 1'b0;
        illegal_s = 1'b0;
        rs1_addr  = instr[19:15];
        case (opcode_s)
            OPC_OP: begin
                if (funct3_s == F3_SLTU) begin
                    illegal_s = 1'b1;
                end else if (funct3_s == F3_ADD && funct7_s == F7_ALT) begin
                    aluop_s = ALU_SUB;
                end else if (funct7_s != F7_ZERO) begin
                    illegal_s = 1'b1;
                end else begin
                    aluop_s = funct3_to_aluop(funct3_s);
                end
            end
            OPC_OP_IMM: begin
                imm_en_s = 1'b1;
                if (funct3_s == F3_SLTU) begin
                    illegal_s = 1'b1;
                end else if (funct3_s == F3_SLL || funct3_s == F3_SR) begin
                    // shift immediates carry a funct7 field; only logical shifts exist here
                    if (funct7_s != F7_ZERO) begin
                        illegal_s = 1'b1;
                    end else begin
                        aluop_s = funct3_to_aluop(funct3_s);
                        imm_s   = XLEN'(instr[24:20]);
                    end
                end else begin
                    aluop_s = funct3_to_aluop(funct3_s);
                    imm_s   = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_LUI: begin
                rs1_addr = 5'd0;
                imm_en_s = 1'b1;
                imm_s    = XLEN'($signed({instr[31:12], 12'h000}));
            end
            OPC_AUIPC: begin
                pc_en_s  = 1'b1;
                imm_en_s = 1'b1;
                imm_s    = XLEN'($signed({instr[31:12], 12'h000}));
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Illegal words become an ADD to x0 so ex sees a harmless no-op
    always_comb begin
        illegal = illegal_s;
        if (illegal_s) begin
            aluop  = ALUOP_W'(ALU_ADD);
            imm    = '0;
            pc_en  = 1'b0;
            imm_en = 1'b0;
            rd     = 5'd0;
        end else begin
            aluop  = ALUOP_W'(aluop_s);
            imm    = imm_s;
            pc_en  = pc_en_s;
            imm_en = imm_en_s;
            rd     = instr[11:7];
        end
    end

endmodule

// File: rtl/id.sv
// Decode stage: single output register slice between fetch and ex, holding
// the decoded operand bundle, a sticky illegal flag and an accept counter.
module id #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               en,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic [4:0]         rs1_addr,
    output logic [4:0]         rs2_addr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    reg_1,
    output logic [XLEN-1:0]    reg_2,
    output logic [XLEN-1:0]    imm,
    output logic [ALUOP_W-1:0] aluop,
    output logic               pc_en,
    output logic               imm_en,
    output logic [4:0]         rd,
    output logic               illegal,
    output logic [15:0]        dec_count
);
    import id_pkg::*;

    logic [ALUOP_W-1:0] dec_aluop_s;
    logic [XLEN-1:0]    dec_imm_s;
    logic               dec_pc_en_s;
    logic               dec_imm_en_s;
    logic               dec_illegal_s;
    logic [4:0]         dec_rd_s;
    logic               accept_s;

    logic               out_valid_d, out_valid_q;
    logic [XLEN-1:0]    pc_d, pc_q;
    logic [XLEN-1:0]    reg_1_d, reg_1_q;
    logic [XLEN-1:0]    reg_2_d, reg_2_q;
    logic [XLEN-1:0]    imm_d, imm_q;
    logic [ALUOP_W-1:0] aluop_d, aluop_q;
    logic               pc_en_d, pc_en_q;
    logic               imm_en_d, imm_en_q;
    logic [4:0]         rd_d, rd_q;
    logic               illegal_d, illegal_q;
    logic [15:0]        dec_count_d, dec_count_q;

    id_dec #(
        .XLEN    (XLEN),
        .ALUOP_W (ALUOP_W)
    ) u_dec (
        .instr    (in_instr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd       (dec_rd_s),
        .aluop    (dec_aluop_s),
        .imm      (dec_imm_s),
        .pc_en    (dec_pc_en_s),
        .imm_en   (dec_imm_en_s),
        .illegal  (dec_illegal_s)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Next state of the output slice; flush has priority over both handshakes
    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        reg_1_d     = reg_1_q;
        reg_2_d     = reg_2_q;
        imm_d       = imm_q;
        aluop_d     = aluop_q;
        pc_en_d     = pc_en_q;
        imm_en_d    = imm_en_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        dec_count_d = dec_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            pc_d        = in_pc;
            reg_1_d     = rs1_data;
            reg_2_d     = rs2_data;
            imm_d       = dec_imm_s;
            aluop_d     = dec_aluop_s;
            pc_en_d     = dec_pc_en_s;
            imm_en_d    = dec_imm_en_s;
            rd_d        = dec_rd_s;
            illegal_d   = illegal_q | dec_illegal_s;
            dec_count_d = dec_count_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output slice registers, cleared asynchronously by rst
    always_ff @(posedge en or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            reg_1_q     <= '0;
            reg_2_q     <= '0;
            imm_q       <= '0;
            aluop_q     <= '0;
            pc_en_q     <= 1'b0;
            imm_en_q    <= 1'b0;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            dec_count_q <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            reg_1_q     <= reg_1_d;
            reg_2_q     <= reg_2_d;
            imm_q       <= imm_d;
            aluop_q     <= aluop_d;
            pc_en_q     <= pc_en_d;
            imm_en_q    <= imm_en_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            dec_count_q <= dec_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign reg_1     = reg_1_q;
    assign reg_2     = reg_2_q;
    assign imm       = imm_q;
    assign aluop     = aluop_q;
    assign pc_en     = pc_en_q;
    assign imm_en    = imm_en_q;
    assign rd        = rd_q;
    assign illegal   = illegal_q;
    assign dec_count = dec_count_q;

endmodule

// File: tb/tb_id.sv
// Self-checking bench for the decode stage: expected bundles are queued as
// instructions are offered and compared when the stage presents them.
module tb_id;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic        pc_en;
        logic        imm_en;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic [2:0]  aluop;
        logic [31:0] imm;
        logic        pc_en;
        logic        imm_en;
        logic [4:0]  rd;
    } vec_t;

    logic        en = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic        out_valid, pc_en, imm_en, illegal;
    logic [31:0] pc, reg_1, reg_2, imm;
    logic [2:0]  aluop;
    logic [15:0] dec_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_m = 16'd0;
    bundle_t     sb[$];

    id #(.XLEN(32), .ALUOP_W(3)) dut (
        .en(en), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .reg_1(reg_1), .reg_2(reg_2), .imm(imm), .aluop(aluop),
        .pc_en(pc_en), .imm_en(imm_en), .rd(rd), .illegal(illegal),
        .dec_count(dec_count)
    );

    initial begin
        forever #5 en = ~en;
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rdi);
        return {f7, rs2, rs1, f3, rdi, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rdi);
        return {im, rs1, f3, rdi, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rdi,
                                          input logic [6:0] opc);
        return {im, rdi, opc};
    endfunction

    function automatic bundle_t mk(input logic [31:0] p, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im,
                                   input logic [2:0] op, input logic pe, input logic ie,
                                   input logic [4:0] d);
        return {p, a, b, im, op, pe, ie, d};
    endfunction

    function automatic bundle_t obs();
        return {pc, reg_1, reg_2, imm, aluop, pc_en, imm_en, rd};
    endfunction

    task automatic cyc();
        @(posedge en);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (dec_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0000", dec_count); end
        checks++; if (obs() !== bundle_t'(0)) begin errors++; $display("FAIL reset_bundle: got %h want 0", obs()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_add();
        bundle_t e;
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        in_pc = 32'h0000_0040; rs1_data = 32'd10; rs2_data = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL add_rs1_addr: got %0d want 1", rs1_addr); end
        checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL add_rs2_addr: got %0d want 2", rs2_addr); end
        sb.push_back(mk(32'h40, 32'd10, 32'd20, 32'd0, 3'd0, 1'b0, 1'b0, 5'd3));
        cnt_m++;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        e = sb.pop_front();
        checks++; if (obs() !== e) begin errors++; $display("FAIL add_bundle: got %h want %h", obs(), e); end
        checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL add_count: got %h want %h", dec_count, cnt_m); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        vec_t    tbl[$];
        bundle_t e;
        tbl.push_back('{enc_r(7'h20, 5'd9, 5'd8, 3'd0, 5'd7),   32'h1000, 5'd8,  3'd1, 32'h0,        1'b0, 1'b0, 5'd7});
        tbl.push_back('{enc_r(7'h00, 5'd12, 5'd11, 3'd7, 5'd10), 32'h1004, 5'd11, 3'd2, 32'h0,        1'b0, 1'b0, 5'd10});
        tbl.push_back('{enc_r(7'h00, 5'd13, 5'd14, 3'd6, 5'd15), 32'h1008, 5'd14, 3'd3, 32'h0,        1'b0, 1'b0, 5'd15});
        tbl.push_back('{enc_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd3),    32'h100C, 5'd2,  3'd4, 32'h0,        1'b0, 1'b0, 5'd3});
        tbl.push_back('{enc_r(7'h00, 5'd4, 5'd5, 3'd1, 5'd6),    32'h1010, 5'd5,  3'd5, 32'h0,        1'b0, 1'b0, 5'd6});
        tbl.push_back('{enc_r(7'h00, 5'd7, 5'd8, 3'd5, 5'd9),    32'h1014, 5'd8,  3'd6, 32'h0,        1'b0, 1'b0, 5'd9});
        tbl.push_back('{enc_r(7'h00, 5'd10, 5'd11, 3'd2, 5'd12), 32'h1018, 5'd11, 3'd7, 32'h0,        1'b0, 1'b0, 5'd12});
        tbl.push_back('{enc_i(12'hFFF, 5'd0, 3'd0, 5'd5),        32'h101C, 5'd0,  3'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd5});
        tbl.push_back('{enc_i(12'h01F, 5'd2, 3'd1, 5'd4),        32'h1020, 5'd2,  3'd5, 32'd31,       1'b0, 1'b1, 5'd4});
        tbl.push_back('{enc_i(12'h004, 5'd3, 3'd5, 5'd8),        32'h1024, 5'd3,  3'd6, 32'd4,        1'b0, 1'b1, 5'd8});
        tbl.push_back('{enc_i(12'h800, 5'd1, 3'd7, 5'd9),        32'h1028, 5'd1,  3'd2, 32'hFFFFF800, 1'b0, 1'b1, 5'd9});
        tbl.push_back('{enc_i(12'h7FF, 5'd3, 3'd4, 5'd2),        32'h102C, 5'd3,  3'd4, 32'h000007FF, 1'b0, 1'b1, 5'd2});
        tbl.push_back('{enc_u(20'hABCDE, 5'd6, 7'b0110111),      32'h1030, 5'd0,  3'd0, 32'hABCDE000, 1'b0, 1'b1, 5'd6});
        tbl.push_back('{enc_u(20'h00001, 5'd1, 7'b0010111),      32'h0100, 5'd0,  3'd0, 32'h00001000, 1'b1, 1'b1, 5'd1});
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            in_instr = tbl[i].instr; in_pc = tbl[i].pc;
            rs1_data = $urandom; rs2_data = $urandom;
            in_valid = 1'b1;
            #1;
            checks++; if (rs1_addr !== tbl[i].rs1a) begin errors++; $display("FAIL b2b_rs1_addr[%0d]: got %0d want %0d", i, rs1_addr, tbl[i].rs1a); end
            sb.push_back(mk(tbl[i].pc, rs1_data, rs2_data, tbl[i].imm, tbl[i].aluop, tbl[i].pc_en, tbl[i].imm_en, tbl[i].rd));
            cnt_m++;
            cyc();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            e = sb.pop_front();
            checks++; if (obs() !== e) begin errors++; $display("FAIL b2b_bundle[%0d]: got %h want %h", i, obs(), e); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL b2b_count: got %h want %h", dec_count, cnt_m); end
    endtask

    task automatic test_stall();
        bundle_t e;
        in_instr = enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd4); in_pc = 32'h2000;
        rs1_data = 32'h1111_0000; rs2_data = 32'h0000_2222;
        in_valid = 1'b1; out_ready = 1'b1;
        sb.push_back(mk(32'h2000, 32'h1111_0000, 32'h0000_2222, 32'd0, 3'd0, 1'b0, 1'b0, 5'd4));
        cnt_m++;
        cyc();
        in_instr = enc_i(12'h123, 5'd7, 3'd6, 5'd8); in_pc = 32'h2004;
        rs1_data = 32'h3333_3333; rs2_data = 32'h4444_4444;
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || obs() !== sb[0]) begin errors++; $display("FAIL stall_bundle[%0d]: got %b/%h want 1/%h", k, out_valid, obs(), sb[0]); end
            checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL stall_count[%0d]: got %h want %h", k, dec_count, cnt_m); end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        e = sb.pop_front();
        checks++; if (obs() !== e) begin errors++; $display("FAIL stall_release_bundle: got %h want %h", obs(), e); end
        sb.push_back(mk(32'h2004, 32'h3333_3333, 32'h4444_4444, 32'h123, 3'd3, 1'b0, 1'b1, 5'd8));
        cnt_m++;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b want 1", out_valid); end
        e = sb.pop_front();
        checks++; if (obs() !== e) begin errors++; $display("FAIL stall_next_bundle: got %h want %h", obs(), e); end
        checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL stall_next_count: got %h want %h", dec_count, cnt_m); end
        cyc();
    endtask

    task automatic test_flush();
        in_instr = enc_i(12'h005, 5'd0, 3'd0, 5'd1); in_pc = 32'h3000;
        in_valid = 1'b1; out_ready = 1'b1;
        cnt_m++;
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup_valid: got %b want 1", out_valid); end
        in_instr = enc_i(12'h006, 5'd0, 3'd0, 5'd2); in_pc = 32'h3004;
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL flush_count: got %h want %h", dec_count, cnt_m); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad[$];
        bundle_t     e;
        bad.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd5));
        bad.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd6));
        bad.push_back(enc_r(7'h01, 5'd2, 5'd1, 3'd6, 5'd7));
        bad.push_back(enc_i(12'h404, 5'd1, 3'd5, 5'd8));
        bad.push_back(enc_i(12'h001, 5'd1, 3'd3, 5'd9));
        bad.push_back(32'hFFFF_FFFF);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pre: got %b want 0", illegal); end
        out_ready = 1'b1;
        foreach (bad[i]) begin
            in_instr = bad[i]; in_pc = 32'h4000 + 32'(i * 4);
            rs1_data = $urandom; rs2_data = $urandom;
            in_valid = 1'b1;
            sb.push_back(mk(in_pc, rs1_data, rs2_data, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0));
            cnt_m++;
            cyc();
            checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag[%0d]: got %b want 1", i, illegal); end
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL illegal_bundle[%0d]: got %b/%h want 1/%h", i, out_valid, obs(), e); end
        end
        in_instr = enc_i(12'h00A, 5'd3, 3'd0, 5'd11); in_pc = 32'h4100;
        sb.push_back(mk(32'h4100, rs1_data, rs2_data, 32'd10, 3'd0, 1'b0, 1'b1, 5'd11));
        cnt_m++;
        cyc();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (obs() !== e) begin errors++; $display("FAIL illegal_legal_bundle: got %h want %h", obs(), e); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
        cyc();
    endtask

    task automatic test_reset_mid();
        bundle_t e;
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3); in_pc = 32'h5000;
        rs1_data = 32'hDEAD_BEEF; rs2_data = 32'hCAFE_F00D;
        in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_held: got %b want 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b0 || dec_count !== 16'd0) begin
            errors++; $display("FAIL rmid_ctrl: got v=%b il=%b cnt=%h want 0/0/0000", out_valid, illegal, dec_count); end
        checks++; if (obs() !== bundle_t'(0)) begin errors++; $display("FAIL rmid_bundle: got %h want 0", obs()); end
        sb.delete();
        cnt_m = 16'd0;
        in_instr = enc_i(12'h0FF, 5'd4, 3'd6, 5'd12); in_pc = 32'h6000;
        rs1_data = 32'h0000_0F0F; rs2_data = 32'h0000_0001;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_in_reset: got %b want 0", out_valid); end
        rst = 1'b1;
        sb.push_back(mk(32'h6000, 32'h0000_0F0F, 32'h0000_0001, 32'h0FF, 3'd3, 1'b0, 1'b1, 5'd12));
        cnt_m++;
        cyc();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL rmid_first: got %b/%h want 1/%h", out_valid, obs(), e); end
        checks++; if (dec_count !== cnt_m) begin errors++; $display("FAIL rmid_count: got %h want %h", dec_count, cnt_m); end
        cyc();
    endtask

    task automatic test_wrap();
        rst = 1'b0;
        #1 rst = 1'b1;
        cnt_m = 16'd0;
        sb.delete();
        in_instr = enc_i(12'h001, 5'd1, 3'd0, 5'd1); in_pc = 32'h7000;
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        repeat (65535) cyc();
        checks++; if (dec_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h want ffff", dec_count); end
        cyc();
        checks++; if (dec_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", dec_count); end
        cyc();
        in_valid = 1'b0;
        checks++; if (dec_count !== 16'h0001) begin errors++; $display("FAIL wrap_one: got %h want 0001", dec_count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id.md
ID -- requirements
Module: id

Interface
REQ-001 Parameter XLEN, 32, data/instruction/pc width.
REQ-002 Parameter ALUOP_W, 3, aluop width.
REQ-003 en  in  1  clock; all state updates on rising edge of en.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  fetch presents in_instr/in_pc.
REQ-006 in_ready  out  1  id accepts this cycle.
REQ-007 in_instr  in  XLEN  instruction word.
REQ-008 in_pc  in  XLEN  instruction address.
REQ-009 flush  in  1  discard held and incoming instruction.
REQ-010 rs1_addr, rs2_addr  out  5 each  register-file read addresses, combinational from in_instr.
REQ-011 rs1_data, rs2_data  in  XLEN each  register-file read data, same cycle.
REQ-012 out_valid  out  1  decoded bundle valid toward ex.
REQ-013 out_ready  in  1  ex consumes bundle.
REQ-014 pc, reg_1, reg_2, imm  out  XLEN each  registered operands for ex.
REQ-015 aluop  out  ALUOP_W  registered operation; pc_en, imm_en  out  1 each  select pc as operand A / imm as operand B.
REQ-016 rd  out  5  destination; illegal  out  1  sticky illegal-instruction flag; dec_count  out  16  accepted-instruction counter.

Function
REQ-017 aluop encoding SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT.
REQ-018 in_ready SHALL equal !out_valid || out_ready (single output register, no bubble on back-to-back).
REQ-019 Accept = in_valid && in_ready && !flush; on accept, all bundle outputs load and out_valid<=1.
REQ-020 out_valid SHALL clear when out_ready && !accept; hold with stable bundle while !out_ready.
REQ-021 flush SHALL clear out_valid next edge and block accept; flush beats in_valid and out_ready.
REQ-022 OP (0110011): funct3 000 -> ADD, or SUB when funct7[5]; 001 SLL; 010 SLT; 100 XOR; 101 SRL (funct7=0 only); 110 OR; 111 AND; imm_en=0, pc_en=0.
REQ-023 OP-IMM (0010011): same funct3 map, no SUB, imm = sign-extended instr[31:20] (shifts: zero-extended instr[24:20]), imm_en=1.
REQ-024 LUI: rs1_addr forced 0, aluop ADD, imm = {instr[31:12],12'b0}, imm_en=1.
REQ-025 AUIPC: pc_en=1, imm_en=1, aluop ADD, imm as LUI.
REQ-026 Any other opcode, funct3 011, SRA, or nonzero unused funct7 SHALL be illegal: bundle issued as ADD with rd=0 (no-op), illegal<=1 sticky.
REQ-027 dec_count SHALL increment by 1 per accept, wrap 0xFFFF -> 0x0000, not count flushed words.
REQ-028 Latency: accept edge N -> out_valid high after edge N; one instruction per cycle sustained.

Reset
REQ-029 rst low SHALL immediately force out_valid=0, illegal=0, dec_count=0, pc/reg_1/reg_2/imm=0, aluop=0, pc_en=imm_en=0, rd=0.
REQ-030 Reset mid-handshake SHALL drop the held bundle; first accept permitted on first edge after rst rises.

Structure
REQ-031 aluop codes and opcode constants SHALL live in the shared CPU define package used by ex.
REQ-032 One combinational sub-module id_dec (instr -> aluop, imm, flags, illegal) SHALL be natural; the registers stay in id.

Verification
REQ-033 ADD x3,x1,x2 with rs1_data=10, rs2_data=20, out_ready=1 -> next cycle out_valid=1, aluop=0, reg_1=10, reg_2=20, rd=3, imm_en=0.
REQ-034 ADDI x5,x0,-1 -> imm=0xFFFFFFFF, imm_en=1, aluop=0; AUIPC at in_pc=0x100 -> pc=0x100, pc_en=1.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable, dec_count unchanged until release.
REQ-036 flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, dec_count unchanged.
REQ-037 instr 0xFFFFFFFF -> illegal=1 stays set, rd=0; rst low mid-stream -> all outputs zero immediately.
REQ-038 65537 accepts -> dec_count=1.
